afe_spi_config: RTL and testbench

AFE_SPI_CONFIG -- requirements
Module: afe_spi_config

---
 rtl/afe_spi_config.sv | 176 +++++++++++++++++
 tb/tb_afe_spi_config.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_spi_config.sv
// afe_spi_config: boots an AFE by streaming a register table out over a 3-wire SPI
// write-only link, then accepts single runtime register writes.
// Ports: clk/reset (sync, active-high); start (reset-timer done level);
//   rom_index/rom_word (boot table, {addr[23:16], data[15:0]}, combinational read);
//   wr_valid/wr_word/wr_ready (runtime write handshake);
//   spi_sen_n/spi_sclk/spi_sdata (serial port); busy, config_done (status).
// Every output comes straight from a flop, so the serial pins are glitch-free.

module afe_spi_config #(
  parameter int CLK_DIV    = 4,  // clk cycles per SCLK half-period
  parameter int NUM_REGS   = 8,  // boot-table entries
  parameter int GAP_CYCLES = 8   // min spi_sen_n high time between frames
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_index,
  input  logic [23:0] rom_word,
  input  logic        wr_valid,
  input  logic [23:0] wr_word,
  output logic        wr_ready,
  output logic        spi_sen_n,
  output logic        spi_sclk,
  output logic        spi_sdata,
  output logic        busy,
  output logic        config_done
);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, SHIFT, HOLD, GAP, READY} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] IDX_LAST = (NUM_REGS > 0) ? 8'(NUM_REGS - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;      // half-period / setup / hold / gap counter
  logic [4:0]  bit_q, bit_d;      // bit being shifted, 0..23
  logic [23:0] shreg_q, shreg_d;  // frame, MSB drives spi_sdata
  logic [7:0]  idx_q, idx_d;
  logic        sclk_q, sclk_d;
  logic        sen_n_q, sen_n_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    sclk_d  = sclk_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        // IDLE is only re-entered through reset, so start can fire the boot once.
        if (start) state_d = FETCH;
      end

      FETCH: begin
        if (NUM_REGS == 0) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          shreg_d = rom_word;
          cnt_d   = 8'd0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        sclk_d = 1'b0;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Data advances on the same edge SCLK falls, so it is stable while SCLK is high.
          if (sclk_q) begin
            shreg_d = {shreg_q[22:0], 1'b0};
            if (bit_q == 5'd23) state_d = HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        sclk_d = 1'b0;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 8'd0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          // config_done still low means this was a boot frame.
          if (!done_q && idx_q != IDX_LAST) begin
            idx_d   = idx_q + 8'd1;
            state_d = FETCH;
          end else begin
            state_d = READY;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      READY: begin
        // wr_ready is high exactly in READY, so wr_valid alone completes the handshake.
        if (wr_valid) begin
          shreg_d = wr_word;
          cnt_d   = 8'd0;
          state_d = SETUP;
        end
      end

      default: state_d = IDLE;
    endcase

    sen_n_d = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    busy_d  = (state_d == FETCH || state_d == SETUP || state_d == SHIFT ||
               state_d == HOLD  || state_d == GAP);
    rdy_d   = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      shreg_q <= 24'd0;
      idx_q   <= 8'd0;
      sclk_q  <= 1'b0;
      sen_n_q <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      sclk_q  <= sclk_d;
      sen_n_q <= sen_n_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign rom_index   = idx_q;
  assign wr_ready    = rdy_q;
  assign spi_sen_n   = sen_n_q;
  assign spi_sclk    = sclk_q;
  assign spi_sdata   = shreg_q[23];
  assign busy        = busy_q;
  assign config_done = done_q;

endmodule

// File: tb/tb_afe_spi_config.sv
module tb_afe_spi_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: CLK_DIV=4, NUM_REGS=2, GAP=8 ----------------
  logic        rst_a, start_a, wr_valid_a, wr_ready_a;
  logic        sen_a, sclk_a, sdata_a, busy_a, done_a;
  logic [7:0]  idx_a;
  logic [23:0] rom_a, wr_word_a;

  assign rom_a = (idx_a == 8'd0) ? 24'h01A5C3 : 24'h7F0001;

  afe_spi_config #(.CLK_DIV(4), .NUM_REGS(2), .GAP_CYCLES(8)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .rom_index(idx_a), .rom_word(rom_a),
    .wr_valid(wr_valid_a), .wr_word(wr_word_a), .wr_ready(wr_ready_a),
    .spi_sen_n(sen_a), .spi_sclk(sclk_a), .spi_sdata(sdata_a),
    .busy(busy_a), .config_done(done_a));

  // ---------------- DUT B: NUM_REGS=0 ----------------
  logic        rst_b, start_b, wr_ready_b, sen_b, sclk_b, sdata_b, busy_b, done_b;
  logic [7:0]  idx_b;
  logic [23:0] rom_b = 24'h0;
  logic        wr_valid_b = 1'b0;
  logic [23:0] wr_word_b = 24'h0;

  afe_spi_config #(.CLK_DIV(4), .NUM_REGS(0), .GAP_CYCLES(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .rom_index(idx_b), .rom_word(rom_b),
    .wr_valid(wr_valid_b), .wr_word(wr_word_b), .wr_ready(wr_ready_b),
    .spi_sen_n(sen_b), .spi_sclk(sclk_b), .spi_sdata(sdata_b),
    .busy(busy_b), .config_done(done_b));

  // ---------------- DUT C: CLK_DIV=1, NUM_REGS=1 ----------------
  logic        rst_c, start_c, wr_ready_c, sen_c, sclk_c, sdata_c, busy_c, done_c;
  logic [7:0]  idx_c;
  logic [23:0] rom_c = 24'hC0FFEE;
  logic        wr_valid_c = 1'b0;
  logic [23:0] wr_word_c = 24'h0;

  afe_spi_config #(.CLK_DIV(1), .NUM_REGS(1), .GAP_CYCLES(8)) dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .rom_index(idx_c), .rom_word(rom_c),
    .wr_valid(wr_valid_c), .wr_word(wr_word_c), .wr_ready(wr_ready_c),
    .spi_sen_n(sen_c), .spi_sclk(sclk_c), .spi_sdata(sdata_c),
    .busy(busy_c), .config_done(done_c));

  // ---------------- SPI monitor for A (samples 1 time unit after the clock edge) ----------------
  logic [23:0] fq[$];
  int          bq[$];
  int          lq[$];
  logic [23:0] acc = 24'h0;
  int nb = 0, lowlen = 0, mcyc = 0, last_end = 0, done_cyc = 0, ready_cyc = 0;
  int min_gap = 9999, viol = 0, max_idx = 0;
  logic have_end = 1'b0;
  logic sen_p = 1'b1, sclk_p = 1'b0, sdata_p = 1'b0, done_p = 1'b0, rdy_p = 1'b0;

  always @(posedge clk) begin
    #1;
    mcyc++;
    if (sen_p === 1'b1 && sen_a === 1'b0) begin
      acc = 24'h0; nb = 0; lowlen = 0;
      if (have_end && (mcyc - last_end) < min_gap) min_gap = mcyc - last_end;
    end
    if (sen_a === 1'b0) begin
      lowlen++;
      if (sclk_p === 1'b0 && sclk_a === 1'b1) begin
        acc = {acc[22:0], sdata_a};
        nb++;
      end
      if (sclk_p === 1'b1 && sclk_a === 1'b1 && sdata_a !== sdata_p) viol++;
    end
    if (sen_p === 1'b0 && sen_a === 1'b1) begin
      fq.push_back(acc); bq.push_back(nb); lq.push_back(lowlen);
      last_end = mcyc; have_end = 1'b1;
    end
    if (done_p === 1'b0 && done_a === 1'b1) done_cyc = mcyc;
    if (rdy_p === 1'b0 && wr_ready_a === 1'b1) ready_cyc = mcyc;
    if (!$isunknown(idx_a) && int'(idx_a) > max_idx) max_idx = int'(idx_a);
    sen_p = sen_a; sclk_p = sclk_a; sdata_p = sdata_a; done_p = done_a; rdy_p = wr_ready_a;
  end

  // ---------------- monitors for B and C ----------------
  logic b_low = 1'b0;
  int c_cnt = 0, c_len = 0;
  logic [23:0] c_acc = 24'h0;
  logic c_sen_p = 1'b1, c_sclk_p = 1'b0;

  always @(posedge clk) begin
    #1;
    if (sen_b === 1'b0) b_low = 1'b1;
    if (sen_c === 1'b0) begin
      c_cnt++;
      if (c_sclk_p === 1'b0 && sclk_c === 1'b1) c_acc = {c_acc[22:0], sdata_c};
    end
    if (c_sen_p === 1'b0 && sen_c === 1'b1) c_len = c_cnt;
    c_sen_p = sen_c; c_sclk_p = sclk_c;
  end

  task automatic clear_mon();
    fq.delete(); bq.delete(); lq.delete();
    have_end = 1'b0; min_gap = 9999; viol = 0; max_idx = 0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    wr_valid_a = 1'b0; wr_word_a = 24'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_sen_n", sen_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_sdata", sdata_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_wr_ready", wr_ready_a, 0);
    check("rst_rom_index", idx_a, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // NUM_REGS=0: FETCH for one cycle, then READY
    @(negedge clk); start_b = 1'b1;
    @(negedge clk);
    check("nr0_fetch_busy", busy_b, 1);
    check("nr0_fetch_done", done_b, 0);
    @(negedge clk);
    check("nr0_done", done_b, 1);
    check("nr0_busy", busy_b, 0);
    check("nr0_wr_ready", wr_ready_b, 1);
    repeat (20) @(negedge clk);
    check("nr0_no_sen_activity", b_low, 0);

    // CLK_DIV=1: 50-cycle frame
    start_c = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_c) break;
    end
    check("div1_done", done_c, 1);
    check("div1_sen_low_len", c_len, 50);
    check("div1_frame", c_acc, 24'hC0FFEE);

    // Boot with start toggled mid-sequence
    clear_mon();
    start_a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 150) start_a = 1'b0;
      if (i == 400) start_a = 1'b1;
      if (i == 420) start_a = 1'b0;
      if (done_a) break;
    end
    check("boot_done", done_a, 1);
    check("boot_frames", fq.size(), 2);
    if (fq.size() == 2) begin
      check("boot_frame0", fq[0], 24'h01A5C3);
      check("boot_frame1", fq[1], 24'h7F0001);
      check("boot_len0", lq[0], 200);
      check("boot_len1", lq[1], 200);
      check("boot_bits0", bq[0], 24);
      check("boot_bits1", bq[1], 24);
    end
    check("boot_sdata_stable_hi", viol, 0);
    check("boot_gap_ge8", min_gap >= 8, 1);
    check("boot_done_after_gap", done_cyc - last_end, 8);
    check("boot_idx_max", max_idx <= 1, 1);

    // Re-pulse start after config_done
    start_a = 1'b1; repeat (5) @(negedge clk);
    start_a = 1'b0; repeat (5) @(negedge clk);
    start_a = 1'b1; repeat (400) @(negedge clk);
    check("repulse_frames", fq.size(), 2);
    check("repulse_busy", busy_a, 0);
    check("repulse_idx", idx_a, 1);
    check("ready_wr_ready", wr_ready_a, 1);

    // Runtime write, single-cycle wr_valid
    wr_word_a = 24'h123456; wr_valid_a = 1'b1;
    @(negedge clk);
    wr_valid_a = 1'b0;
    check("wr_ready_drop", wr_ready_a, 0);
    check("wr_busy", busy_a, 1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wr_ready_a) break;
    end
    check("wr_ready_back", wr_ready_a, 1);
    check("wr_frames", fq.size(), 3);
    if (fq.size() == 3) begin
      check("wr_frame", fq[2], 24'h123456);
      check("wr_len", lq[2], 200);
    end
    check("wr_ready_after_gap", ready_cyc - last_end, 8);

    // Runtime write with wr_valid held through busy
    wr_word_a = 24'hABCDEF; wr_valid_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wr_ready_a) begin
        wr_valid_a = 1'b0;
        break;
      end
    end
    wr_valid_a = 1'b0;
    repeat (300) @(negedge clk);
    check("held_frames", fq.size(), 4);
    if (fq.size() == 4) check("held_frame", fq[3], 24'hABCDEF);
    check("held_wr_ready", wr_ready_a, 1);

    // Reset mid-frame, then full re-boot
    rst_a = 1'b1; @(negedge clk);
    rst_a = 1'b0; start_a = 1'b1;
    clear_mon();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sen_a === 1'b0 && nb == 10) break;
    end
    check("midrst_reached_bit10", nb, 10);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_sen_n", sen_a, 1);
    check("midrst_sclk", sclk_a, 0);
    check("midrst_idx", idx_a, 0);
    check("midrst_busy", busy_a, 0);
    rst_a = 1'b0;
    clear_mon();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    check("reboot_done", done_a, 1);
    check("reboot_frames", fq.size(), 2);
    if (fq.size() == 2) begin
      check("reboot_frame0", fq[0], 24'h01A5C3);
      check("reboot_frame1", fq[1], 24'h7F0001);
    end
    check("reboot_idx_max", max_idx <= 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
